pattern_gen: RTL and testbench
==============================

# pattern_gen

Sixteen-entry digital pattern generator for the ASICLA logic-analyzer tile, driving the opposite direction to the capture path. A host loads up to 16 byte-wide samples through a simple write port, then triggers playback. The block replays the samples in order onto an 8-bit output bus at a programmable rate, either once or looping. It sits beside the capture block, so a loaded pattern can be fed back into the analyzer inputs for self-test.

## Interface
- DEPTH, 16: pattern memory entries; fixed at 16, pointers are 4 bits.
- WIDTH, 8: sample width in bits.
- DIV_W, 8: width of the rate divider field.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe for pattern memory; honoured only in IDLE.
- wr_addr  in  4  write address.
- wr_data  in  WIDTH  write data.
- start  in  1  single-cycle synchronous start pulse (already synchronised upstream).
- stop  in  1  single-cycle synchronous abort pulse.
- loop  in  1  repeat mode; sampled at start.
- last_idx  in  4  index of the final sample, so 1..16 samples play; sampled at start.
- div  in  DIV_W  each sample is held div+1 cycles; sampled at start.
- pat_out  out  WIDTH  current pattern value (registered).
- strobe  out  1  one-cycle pulse on every cycle in which pat_out takes a new sample.
- busy  out  1  high while in RUN.
- done  out  1  sticky; set on normal (non-loop) completion.

## Operation
- Reset values: all memory entries 0x00, pat_out=0, strobe=0, busy=0, done=0, state IDLE, pointer 0, hold counter 0, latched config 0.
- State IDLE:
  - wr_en=1 writes wr_data to mem[wr_addr].
  - start=1 with stop=0 captures loop, last_idx and div, loads pat_out with mem[0], pulses strobe, sets busy=1, clears done, sets pointer=0 and hold counter=div, and moves to RUN.
  - stop alone has no effect.
- State RUN:
  - If the hold counter is non-zero, it decrements.
  - If the hold counter is zero and pointer≠last_idx: pointer+1, pat_out←mem[pointer+1], strobe=1, hold counter←div.
  - If the hold counter is zero, pointer=last_idx and loop=1: pointer←0, pat_out←mem[0], strobe=1, hold counter←div.
  - If the hold counter is zero, pointer=last_idx and loop=0: go to IDLE with busy=0 and done=1. pat_out holds mem[last_idx]; no strobe.
- stop=1 in RUN moves to IDLE at the next edge with busy=0 and done=0. pat_out holds its current value, no strobe is issued, and stop has priority over every other RUN transition.
- In RUN, wr_en and start are ignored. Memory is never modified during playback.
- Simultaneous events:
  - start and stop in the same IDLE cycle: stop wins, nothing starts.
  - wr_en and start in the same IDLE cycle: the write commits, and pat_out gets the pre-write mem[0] if wr_addr=0.
- Pointer and divider arithmetic is unsigned. The pointer never exceeds last_idx, and no wrap past 15 is possible because last_idx≤15.
- Looping playback ends only through stop or reset.
- Reset mid-run: immediate return to reset values, including clearing the memory.

## Timing
- Write latency is 1 cycle: data written at edge N is readable by a start sampled at edge N+1.
- Start latency is 1 cycle: start sampled at edge T gives pat_out=mem[0], strobe=1 and busy=1 in the cycle after T.
- Each sample is visible for exactly div+1 cycles. Strobe is high only in the first of those cycles.
- A non-loop run keeps busy high for exactly (last_idx+1)·(div+1) cycles. done rises at the same edge at which busy falls.
- In loop mode, the mem[last_idx]→mem[0] transition has the same spacing as every other transition, with no bubble.
- A new start is accepted in the first IDLE cycle after completion or abort.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 to addresses 0–3; start with last_idx=3, div=0, loop=0. Required response:
  - pat_out is 11,22,33,44 on four consecutive cycles.
  - strobe is high for all 4 cycles.
  - busy is high for 4 cycles, then done=1 with pat_out held at 0x44.
- Same pattern with div=2. Required: each value is held 3 cycles, strobe pulses every 3rd cycle, and busy is high for 12 cycles.
- loop=1, last_idx=1, mem={0xA5,0x5A}, div=0. Required: pat_out alternates A5/5A every cycle for 20+ cycles with done=0. A stop pulse then gives busy=0 and done=0 on the next cycle, with the value held.
- During a run, pulse wr_en to address 0 with 0xFF and pulse start. Required: playback continues unchanged, and after completion mem[0] still replays its old value.
- In IDLE, assert start and stop together. Required: busy stays 0. Then assert start and wr_en to address 0 with 0x77 together. Required: the first pat_out is the old mem[0], and the next run outputs 0x77.
- Assert rst_n low mid-run. Required: pat_out, busy, done and strobe all read 0 immediately. A subsequent start with last_idx=0 outputs 0x00.

Source files
------------

// File: rtl/pattern_gen_if.sv
// Host-side bundle for the pattern generator: write port, playback control and pattern outputs.
// start/stop are single-cycle pulses sampled on the rising edge; strobe marks each new pat_out sample.
interface pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
);
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             stop;
    logic             loop;
    logic [3:0]       last_idx;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] pat_out;
    logic             strobe;
    logic             busy;
    logic             done;
    logic             state_dbg;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop, last_idx, div,
        input  pat_out, strobe, busy, done, state_dbg
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop, last_idx, div,
        output pat_out, strobe, busy, done, state_dbg
    );
endinterface

// File: rtl/pattern_gen.sv
// Sixteen-entry pattern generator: host loads samples in IDLE, then replays them
// once or looping, holding each sample for div+1 cycles.
module pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    pattern_gen_if.slave  bus
);
    localparam int DEPTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [3:0]       ptr_q, ptr_d;
    logic [DIV_W-1:0] hold_q, hold_d;
    logic             loop_q, loop_d;
    logic [3:0]       last_q, last_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic [3:0]       ptr_inc;

    assign ptr_inc = ptr_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            loop_q   <= 1'b0;
            last_q   <= '0;
            div_q    <= '0;
            pat_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            loop_q   <= loop_d;
            last_q   <= last_d;
            div_q    <= div_d;
            pat_q    <= pat_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        loop_d   = loop_q;
        last_d   = last_q;
        div_d    = div_q;
        pat_d    = pat_q;
        strobe_d = 1'b0;
        done_d   = done_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

        case (state_q)
            IDLE: begin
                if (bus.wr_en) mem_d[bus.wr_addr] = bus.wr_data;
                // Start reads mem_q, so a same-cycle write to entry 0 is not seen until the next run.
                if (bus.start && !bus.stop) begin
                    loop_d   = bus.loop;
                    last_d   = bus.last_idx;
                    div_d    = bus.div;
                    pat_d    = mem_q[0];
                    strobe_d = 1'b1;
                    done_d   = 1'b0;
                    ptr_d    = 4'd0;
                    hold_d   = bus.div;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - DIV_W'(1);
                end else if (ptr_q != last_q) begin
                    ptr_d    = ptr_inc;
                    pat_d    = mem_q[ptr_inc];
                    strobe_d = 1'b1;
                    hold_d   = div_q;
                end else if (loop_q) begin
                    ptr_d    = 4'd0;
                    pat_d    = mem_q[0];
                    strobe_d = 1'b1;
                    hold_d   = div_q;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pat_out   = pat_q;
    assign bus.strobe    = strobe_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: single-shot, divided, looping, ignored writes,
// simultaneous start/stop and start/write, and reset mid-run.
module tb_pattern_gen;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pattern_gen_if #(.WIDTH(8), .DIV_W(8)) bus ();

    pattern_gen #(.WIDTH(8), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and outputs are both handled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] last, input logic [7:0] dv, input logic lp);
        bus.start    = 1'b1;
        bus.last_idx = last;
        bus.div      = dv;
        bus.loop     = lp;
        tick();
        bus.start    = 1'b0;
        bus.wr_en    = 1'b0;
    endtask

    logic [7:0] vals [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.start = 0; bus.stop = 0; bus.loop = 0; bus.last_idx = 0; bus.div = 0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_pat", bus.pat_out, 0);
        check("rst_strobe", bus.strobe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        tick();

        // Single shot, div=0
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) wr(i[3:0], vals[i]);
        do_start(4'd3, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("d0_pat", bus.pat_out, vals[i]);
            check("d0_strobe", bus.strobe, 1);
            check("d0_busy", bus.busy, 1);
            tick();
        end
        check("d0_end_busy", bus.busy, 0);
        check("d0_end_done", bus.done, 1);
        check("d0_end_pat", bus.pat_out, 8'h44);
        check("d0_end_strobe", bus.strobe, 0);
        tick();

        // Same pattern, div=2: 12 busy cycles, strobe every third
        do_start(4'd3, 8'd2, 1'b0);
        check("d2_done_clr", bus.done, 0);
        for (int i = 0; i < 12; i++) begin
            check("d2_pat", bus.pat_out, vals[i/3]);
            check("d2_strobe", bus.strobe, (i % 3 == 0) ? 1 : 0);
            check("d2_busy", bus.busy, 1);
            tick();
        end
        check("d2_end_busy", bus.busy, 0);
        check("d2_end_done", bus.done, 1);
        check("d2_end_pat", bus.pat_out, 8'h44);

        // Loop of two samples, then abort
        wr(4'd0, 8'hA5);
        wr(4'd1, 8'h5A);
        do_start(4'd1, 8'd0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            check("lp_pat", bus.pat_out, (i % 2 == 0) ? 8'hA5 : 8'h5A);
            check("lp_strobe", bus.strobe, 1);
            check("lp_done", bus.done, 0);
            check("lp_busy", bus.busy, 1);
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_busy", bus.busy, 0);
        check("stop_done", bus.done, 0);
        check("stop_pat", bus.pat_out, 8'hA5);
        check("stop_strobe", bus.strobe, 0);

        // Writes and start during a run are ignored; mem = {A5,5A,33,44}
        vals[0] = 8'hA5; vals[1] = 8'h5A;
        do_start(4'd3, 8'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("ign_pat", bus.pat_out, vals[i/2]);
            check("ign_busy", bus.busy, 1);
            if (i == 1) begin
                bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'hFF; bus.start = 1'b1;
            end
            tick();
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
        end
        check("ign_done", bus.done, 1);
        do_start(4'd0, 8'd0, 1'b0);
        check("ign_mem0", bus.pat_out, 8'hA5);
        tick();
        check("ign_done2", bus.done, 1);

        // start with stop in IDLE: nothing starts
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss_busy", bus.busy, 0);
        check("ss_strobe", bus.strobe, 0);

        // start with write to entry 0: old value plays, new value next run
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 8'h77;
        do_start(4'd0, 8'd0, 1'b0);
        check("sw_pat_old", bus.pat_out, 8'hA5);
        check("sw_busy", bus.busy, 1);
        tick();
        check("sw_done", bus.done, 1);
        do_start(4'd0, 8'd0, 1'b0);
        check("sw_pat_new", bus.pat_out, 8'h77);
        tick();

        // Reset mid-run clears outputs at once and wipes memory
        do_start(4'd3, 8'd0, 1'b0);
        tick();
        check("rr_pat_pre", bus.pat_out, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("rr_pat", bus.pat_out, 0);
        check("rr_busy", bus.busy, 0);
        check("rr_done", bus.done, 0);
        check("rr_strobe", bus.strobe, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(4'd0, 8'd0, 1'b0);
        check("rr_start_pat", bus.pat_out, 0);
        check("rr_start_strobe", bus.strobe, 1);
        check("rr_start_busy", bus.busy, 1);
        tick();
        check("rr_end_done", bus.done, 1);
        check("rr_end_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
